seq_mult8: RTL and testbench
============================

Name: seq_mult8

Overview:
- Sequential 8x8 unsigned shift-add multiplier sitting directly upstream of the 8-bit ripple adder (Adder8bit).
- Drives the adder's a/b/c inputs each step and consumes its s/co outputs.
- One iteration per clock, start/busy/done handshake.
- Result feeds the arithmetic datapath alongside the plain adder.

Parameters:
- WIDTH, 8, operand width; only 8 is legal (adder is fixed 8-bit); result is 2*WIDTH.
- CNT_W, 4, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  8  multiplicand, captured on accepted start
- b  input  8  multiplier, captured on accepted start
- product  output  16  registered result {acc,q}; valid when done=1, held until next accepted start
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle pulse; product valid

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; acc, q, m, count, product all 0; busy=0, done=0.
  - Overrides any in-flight operation, no partial result kept.
- Registers:
  - m[7:0]: multiplicand.
  - acc[7:0]: upper partial product.
  - q[7:0]: multiplier/lower partial product.
  - count[CNT_W-1:0].
- Adder hookup:
  - One Adder8bit instance: a=acc, b=(q[0] ? m : 8'h00), c=0.
  - Outputs sum[7:0], co.
- State IDLE:
  - busy=0.
  - On start=1: m<=a, q<=b, acc<=0, count<=0, go RUN.
  - Otherwise stay.
- State RUN (each cycle):
  - {acc,q} <= {co,sum,q[7:1]}: a 17-bit value right-shifted one place.
  - count<=count+1.
  - When count==WIDTH-1 (8th step): go DONE.
- State DONE (one cycle):
  - done=1, product={acc,q}, busy=1.
  - Next state IDLE.
- Latency:
  - Start sampled at edge N: RUN on edges N+1..N+8, done high in cycle after edge N+8.
  - 9 cycles start-to-done; a new start is accepted the cycle after done.
- start while busy (RUN/DONE) is ignored, not queued; operands a/b may change freely then.
- Arithmetic:
  - Unsigned, exact: product = a*b, max 0xFF*0xFF = 0xFE01.
  - Adder carry is never lost because co is shifted into acc[7].
- product register updates only in DONE; stable between operations; 0 after reset until the first completion.
- done and busy are registered outputs (state decode from flops), no combinational path from start.

Decomposition:
- Shared constant header (`include`): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; MULT_W=8.
- One sub-module: reuse the existing Adder8bit as the step adder; no new sub-module.
- FSM, counter and shift registers stay in seq_mult8.

Test Plan:
- Reset then a=8'd13, b=8'd11, start 1 cycle:
  - busy rises next cycle.
  - done pulses exactly 9 cycles after start edge.
  - product=16'h008F.
- a=8'hFF, b=8'hFF: product=16'hFE01, exercises co into acc every step.
- a=8'h00, b=8'hA5 and a=8'h80, b=8'h02: product=16'h0000 then 16'h0100; back-to-back, second start in the cycle after done is accepted.
- Start held high continuously with a=3, b=5 changing to a=7, b=7 mid-RUN: only the first is taken, product=16'h000F; start is re-sampled in IDLE.
- Reset asserted at 4th RUN cycle: next cycle busy=0, done=0, product=0; done never pulses for the aborted op; a subsequent 2*3 yields 16'h0006.
- Random 1000 operand pairs vs. reference a*b; check done width is exactly 1 cycle and product holds between ops.

Source files
------------

// File: rtl/seq_mult8_pkg.sv
// Shared state encodings and operand width for the sequential multiplier.
package seq_mult8_pkg;

  localparam int unsigned MULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : seq_mult8_pkg

// File: rtl/Adder8bit.sv
// 8-bit ripple-carry adder: s = a + b + c, carry out on co.
module Adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c,
  output logic [7:0] s,
  output logic       co
);

  logic [8:0] carry;

  // Ripple the carry through eight full-adder stages.
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = c;
    for (int i = 0; i < 8; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end
    co = carry[8];
  end

endmodule : Adder8bit

// File: rtl/seq_mult8.sv
// Sequential unsigned shift-add multiplier: one partial-product step per clock
// through a shared 8-bit ripple adder, start/busy/done handshake.
module seq_mult8
  import seq_mult8_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_W,
  parameter int unsigned CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   add_b_c;
  logic [WIDTH-1:0]   sum_c;
  logic               co_c;
  logic               last_step_c;

  // Addend is the multiplicand when the current multiplier LSB is set.
  assign add_b_c     = q_q[0] ? m_q : '0;
  assign last_step_c = (count_q == CNT_W'(WIDTH - 1));

  Adder8bit u_step_adder (
    .a  (acc_q),
    .b  (add_b_c),
    .c  (1'b0),
    .s  (sum_c),
    .co (co_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state, datapath next values and registered-output decode.
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    count_d   = count_q;
    product_d = product_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Carry is shifted into acc MSB so no product bit is lost.
        {acc_d, q_d} = {co_c, sum_c, q_q[WIDTH-1:1]};
        count_d      = count_q + CNT_W'(1);
        if (last_step_c) begin
          product_d = {co_c, sum_c, q_q[WIDTH-1:1]};
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule : seq_mult8

// File: tb/tb_seq_mult8.sv
// Directed and random checks of seq_mult8 against hand-computed products.
module tb_seq_mult8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  seq_mult8 dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for done; returns number of edges elapsed since the call.
  task automatic wait_done(output int edges, output bit seen);
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      step();
      edges++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  // Full operation: start pulse, latency, result, one-cycle done, hold.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic [15:0] exp, input bit full);
    int edges;
    bit seen;
    a     = op_a;
    b     = op_b;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = ~op_a;
    b     = ~op_b;
    if (full) check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(edges, seen);
    edges++;
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    // Start sampled at edge N, done visible after edge N+8.
    if (full) check({tag, "_latency"}, 32'(edges), 32'd8 + 32'd1);
    check({tag, "_product"}, 32'(product), 32'(exp));
    if (full) check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    step();
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin : main
    int  edges;
    bit  seen;
    bit  spurious;
    logic [7:0] ra, rb;

    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b0;
    step();

    run_op("13x11", 8'd13, 8'd11, 16'h008F, 1'b1);
    run_op("ffxff", 8'hFF, 8'hFF, 16'hFE01, 1'b1);
    // Back-to-back: second start issued in the cycle after done.
    run_op("00xa5", 8'h00, 8'hA5, 16'h0000, 1'b1);
    run_op("80x02", 8'h80, 8'h02, 16'h0100, 1'b1);

    // Start held high; operands change mid-RUN and must be ignored.
    a     = 8'd3;
    b     = 8'd5;
    start = 1'b1;
    step();
    check("held_busy", 32'(busy), 32'd1);
    step();
    a = 8'd7;
    b = 8'd7;
    wait_done(edges, seen);
    check("held_done_seen", 32'(seen), 32'd1);
    check("held_product", 32'(product), 32'h000F);
    step();
    check("held_idle_busy", 32'(busy), 32'd0);
    step();
    check("held_resample_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(edges, seen);
    check("held2_done_seen", 32'(seen), 32'd1);
    check("held2_product", 32'(product), 32'h0031);
    step();

    // Abort in the 4th RUN cycle.
    a     = 8'd9;
    b     = 8'd9;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0) spurious = 1'b1;
    end
    check("abort_no_done", 32'(spurious), 32'd0);
    run_op("2x3", 8'd2, 8'd3, 16'h0006, 1'b1);

    // Random operands against reference multiply.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op("rand", ra, rb, 16'(ra) * 16'(rb), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_seq_mult8
